// File: rtl/shift_engine_pkg.sv
// Shared constants, FSM encoding and helpers for the I2C shift engine.
// The ACK state only exists when SHIFT_ENGINE_ACK_EN is defined.
package shift_engine_pkg;

    localparam logic RX = 1'b0;
    localparam logic TX = 1'b1;

    localparam logic [1:0] SS_10_BIT_ADDRESS_BYTE_1 = 2'd0;
    localparam logic [1:0] SS_10_BIT_ADDRESS_BYTE_2 = 2'd1;
    localparam logic [1:0] SS_7_BIT_ADDRESS         = 2'd2;
    localparam logic [1:0] SS_TX_FIFO               = 2'd3;

    typedef enum logic [1:0] {
`ifdef SHIFT_ENGINE_ACK_EN
        StIdle  = 2'd0,
        StShift = 2'd1,
        StAck   = 2'd2
`else
        StIdle  = 2'd0,
        StShift = 2'd1
`endif
    } state_t;

    function automatic logic [7:0] reverse8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_load_formatter.sv
// Combinational load mux: formats address bytes or passes TX data through,
// placing the 8-bit address byte at the end that is shifted out first.
module shift_load_formatter
    import shift_engine_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic [9:0]        bus_address,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [1:0]        shift_input_select,
    input  logic              data_direction,
    output logic [DATA_W-1:0] load_value
);

    logic       rw;
    logic [7:0] fb;

    // I2C R/W bit: 1 means the master reads.
    assign rw = (data_direction == RX);

    always_comb begin
        fb = 8'hFF;
        unique case (shift_input_select)
            SS_10_BIT_ADDRESS_BYTE_1: fb = {5'b11110, bus_address[9:8], rw};
            SS_10_BIT_ADDRESS_BYTE_2: fb = bus_address[7:0];
            SS_7_BIT_ADDRESS:         fb = {bus_address[6:0], rw};
            default:                  fb = 8'hFF;
        endcase
    end

    always_comb begin
        load_value = '1;
        if (shift_input_select == SS_TX_FIFO) begin
            load_value = tx_data;
        end else if (MSB_FIRST) begin
            load_value[DATA_W-1 -: 8] = fb;
        end else begin
            // LSB-first: reverse so the address MSB still leaves the wire first.
            load_value[7:0] = reverse8(fb);
        end
    end

endmodule

// File: rtl/shift_engine.sv
// Parametrised I2C serial shift engine with bit counting and RX capture.
// Optional ACK-bit handling is enabled with the SHIFT_ENGINE_ACK_EN macro.
module shift_engine
    import shift_engine_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned CW       = $clog2(DATA_W + 2)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [9:0]        bus_address,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [1:0]        shift_input_select,
    input  logic              data_direction,
    input  logic              shift_direction,
    input  logic              shift_strobe,
    input  logic              shift_in,
    input  logic              shift_load,
`ifdef SHIFT_ENGINE_ACK_EN
    input  logic              ack_drive,
    output logic              ack_nack,
    output logic              ack_valid,
`endif
    output logic              shift_out,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              word_done,
    output logic [CW-1:0]     bit_count,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              word_done_q, word_done_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     count_inc;
    logic [DATA_W-1:0] load_value;
    logic [DATA_W-1:0] shifted;
    logic              in_bit;
`ifdef SHIFT_ENGINE_ACK_EN
    logic              ack_nack_q, ack_nack_d;
    logic              ack_valid_q, ack_valid_d;
`endif

    shift_load_formatter #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_formatter (
        .bus_address        (bus_address),
        .tx_data            (tx_data),
        .shift_input_select (shift_input_select),
        .data_direction     (data_direction),
        .load_value         (load_value)
    );

    // TX shifts release the line by feeding ones behind the outgoing bits.
    assign in_bit    = (shift_direction == RX) ? shift_in : 1'b1;
    assign shifted   = MSB_FIRST ? {data_q[DATA_W-2:0], in_bit} : {in_bit, data_q[DATA_W-1:1]};
    assign count_inc = (count_q == '1) ? count_q : count_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        rx_data_d   = rx_data_q;
        count_d     = count_q;
        rx_valid_d  = 1'b0;
        word_done_d = 1'b0;
`ifdef SHIFT_ENGINE_ACK_EN
        ack_nack_d  = ack_nack_q;
        ack_valid_d = 1'b0;
`endif
        if (shift_load) begin
            data_d  = load_value;
            count_d = '0;
            state_d = StShift;
        end else if (shift_strobe) begin
            case (state_q)
                StIdle: data_d = shifted;
                StShift: begin
                    data_d  = shifted;
                    count_d = count_inc;
                    if (count_inc == CW'(DATA_W)) begin
                        word_done_d = 1'b1;
                        if (shift_direction == RX) begin
                            rx_data_d  = shifted;
                            rx_valid_d = 1'b1;
                        end
`ifdef SHIFT_ENGINE_ACK_EN
                        state_d = StAck;
`else
                        state_d = StIdle;
`endif
                    end
                end
`ifdef SHIFT_ENGINE_ACK_EN
                StAck: begin
                    // Ninth bit: the data word is complete, so data_q holds.
                    count_d = count_inc;
                    if (shift_direction == TX) begin
                        ack_nack_d  = shift_in;
                        ack_valid_d = 1'b1;
                    end
                    state_d = StIdle;
                end
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= StIdle;
            data_q      <= '1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            word_done_q <= 1'b0;
            count_q     <= '0;
`ifdef SHIFT_ENGINE_ACK_EN
            ack_nack_q  <= 1'b0;
            ack_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            word_done_q <= word_done_d;
            count_q     <= count_d;
`ifdef SHIFT_ENGINE_ACK_EN
            ack_nack_q  <= ack_nack_d;
            ack_valid_q <= ack_valid_d;
`endif
        end
    end

`ifdef SHIFT_ENGINE_ACK_EN
    assign ack_nack  = ack_nack_q;
    assign ack_valid = ack_valid_q;
    assign shift_out = (state_q == StAck && shift_direction == RX) ? ack_drive
                     : (MSB_FIRST ? data_q[DATA_W-1] : data_q[0]);
`else
    assign shift_out = MSB_FIRST ? data_q[DATA_W-1] : data_q[0];
`endif

    assign data_out  = data_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign word_done = word_done_q;
    assign bit_count = count_q;
    assign busy      = (state_q != StIdle);

endmodule
